qbus_dl11: RTL and testbench
============================

Name: qbus_dl11

Overview:
- Synthesizable QBUS responder implementing the DL11-style console terminal at I/O-page offsets 17560–17566; it is the target end of the F-11 bus cycles.
- Decodes address phases, answers DATI/DATO(B) and interrupt-acknowledge cycles with RPLY, and serializes XBUF bytes onto a UART line.
- Receive bytes arrive on a parallel strobe port.
- Sits on the external inverted QBUS; AD tri-state buffers live outside this block.

Parameters:
- BASE, 13'o17560, I/O-page offset of RCSR (RBUF +2, XCSR +4, XBUF +6).
- RX_VEC, 16'o000060, receiver interrupt vector.
- TX_VEC, 16'o000064, transmitter interrupt vector.
- BAUD_DIV, 16'd434, pin_clk cycles per serial bit; must be ≥2.
- RPLY_DLY, 2, pin_clk cycles from detected DIN/DOUT to RPLY assertion; range 0..7.

Ports:
- pin_clk  in  1  system clock; all state changes on rising edge.
- pin_init_n  in  1  asynchronous active-low reset (bus INIT).
- pin_ad_n  in  16  inverted AD bus as seen at pins.
- ad_out_n  out  16  inverted read data/vector to drive onto AD.
- ad_oe  out  1  enable for external AD drivers.
- pin_sync_n / pin_din_n / pin_dout_n / pin_wtbt_n / pin_bs_n / pin_iako_n  in  1 each  QBUS strobes, active low.
- pin_rply_n  out  1  reply, active low, for open-drain driver.
- pin_virq_n  out  1  vectored interrupt request, active low.
- rx_data  in  8  received byte.
- rx_stb  in  1  one-cycle strobe loading rx_data.
- txd  out  1  serial transmit line, idle high.

Behaviour:
- Reset (pin_init_n low, async): rply_n=1, ad_oe=0, ad_out_n=16'hFFFF, virq_n=1, txd=1; RIE=XIE=0, DONE=0, OVR=0, RDY=1, tx FSM IDLE, request flops cleared.
- All bus strobes pass through 2-flop synchronizers. Edges are detected on the synchronized versions.
- Address phase (sync falls): latch addr=~ad[12:0], io=~bs_n, wr=~wtbt. Set sel when io and addr[12:3]==BASE[12:3].
- Data phase:
  - DIN low with sync low and sel: decode addr[2:1]:
    - RCSR = {8'b0, DONE, RIE, 6'b0}
    - RBUF = {OVR, OVR, 6'b0, rbuf}; the RBUF read clears DONE and OVR.
    - XCSR = {8'b0, RDY, XIE, 6'b0}
    - XBUF = 0.
  - Drive ad_out_n = ~data and ad_oe=1 immediately. Assert rply_n RPLY_DLY cycles later.
  - DOUT low with sel: on the DOUT detect cycle, write the bits:
    - RCSR[6] → RIE; XCSR[6] → XIE.
    - XBUF: if RDY, load the byte, clear RDY, start tx. If not RDY, ignore the write.
    - Byte write (wtbt low in data phase) with addr[0]=1 updates nothing.
  - Assert rply_n after RPLY_DLY.
  - DIN/DOUT rising (synchronized): release rply_n and ad_oe on the next cycle. Sync rising clears sel.
- IAK: DIN low, sync high, iako low, and a request pending.
  - Drive the vector: RX_VEC if rx request, else TX_VEC. Receiver has priority.
  - Clear that request flop. Reply as in the DIN case.
- Requests:
  - rx_req is set on a 0→1 transition of DONE&RIE. tx_req is set on a 0→1 transition of RDY&XIE.
  - Setting XIE while RDY=1 counts as a transition.
  - Each flop is cleared by its IAK or when its condition goes 0.
  - virq_n = ~(rx_req|tx_req).
- rx_stb: rbuf←rx_data, DONE←1. If DONE was already 1, also set OVR. rx_stb coinciding with an RBUF read: the new byte wins, DONE=1, OVR=0.
- Tx FSM:
  - States: IDLE → START → DATA(8, LSB first) → STOP → IDLE.
  - Each state lasts BAUD_DIV cycles.
  - RDY returns to 1 on the cycle STOP expires.
- Reset mid-cycle or mid-transmission: immediate return to reset values; txd=1.

Optional Feature:
- QBUS_DL11_MAINT_EN defined:
  - XCSR bit2 is MAINT (R/W, reset 0).
  - While MAINT=1, txd is held at 1. The transmitted byte is loaded into rbuf exactly as an rx_stb at STOP expiry, including the OVR rule.
- Undefined: bit2 reads 0, writes are ignored, no loopback logic.

Decomposition:
- Package qbus_dl11_pkg holds:
  - register offset constants (RCSR_OFS..XBUF_OFS)
  - CSR bit positions (DONE=7, IE=6, MAINT=2, OVR=14/15)
  - the tx state enum.
- One sub-module, dl11_tx: BAUD_DIV divider plus 8N1 serializer. Interface: load, data[7:0], busy, done pulse, txd.

Test Plan:
- Reset, then DATI at 177564 → AD reads ~16'o000200, rply_n low 2+sync cycles after DIN, released after DIN rises.
- DATO 16'o000101 to XBUF with BAUD_DIV=4 → XCSR reads 0 during transmit, txd shows 0,1,0,0,0,0,0,1,0,1 at 4 cycles per bit, then XCSR=16'o000200.
- DATO 16'o000100 to XCSR with RDY=1 → virq_n low. IAK cycle → vector 16'o000064, virq_n high, no re-request until RDY toggles.
- Two rx_stb (8'h41, 8'h42) with no read → RBUF reads 16'o140102. A second read returns bit15/14=0 and RCSR DONE=0.
- rx and tx requests both pending → first IAK returns 060, second returns 064.
- MAINT_EN: XCSR=16'o000004, XBUF=8'h55 → txd stays 1, RBUF=8'h55 and DONE=1 after 10 bit times.

Source files
------------

// File: rtl/qbus_dl11_pkg.sv
// qbus_dl11_pkg -- shared constants for the DL11 console terminal responder.
// Holds register offsets (addr[2:1]), CSR bit positions and the tx state enum.
package qbus_dl11_pkg;

  // Register select, taken from addr[2:1]
  localparam logic [1:0] RCSR_OFS = 2'd0;
  localparam logic [1:0] RBUF_OFS = 2'd1;
  localparam logic [1:0] XCSR_OFS = 2'd2;
  localparam logic [1:0] XBUF_OFS = 2'd3;

  // CSR bit positions
  localparam int DONE_BIT   = 7;   // RCSR DONE, XCSR RDY
  localparam int IE_BIT     = 6;   // RIE / XIE
  localparam int MAINT_BIT  = 2;   // XCSR loopback
  localparam int OVR_LO_BIT = 14;
  localparam int OVR_HI_BIT = 15;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

endpackage

// File: rtl/dl11_tx.sv
// dl11_tx -- baud divider plus 8N1 serializer.
// Ports: clk_i/rst_ni (async low), load_i + data_i start a frame from IDLE,
// busy_o high outside IDLE, done_o pulses on the cycle STOP expires,
// txd_o serial line (idle high). Every state lasts BAUD_DIV clocks.
module dl11_tx
  import qbus_dl11_pkg::*;
#(
  parameter logic [15:0] BAUD_DIV = 16'd434
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [7:0] data_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       txd_o
);

  tx_state_e   state_q;
  logic [15:0] cnt_q;
  logic [7:0]  shift_q;
  logic [2:0]  bit_q;
  logic        txd_q;
  logic        tick;

  assign tick   = (cnt_q == BAUD_DIV - 16'd1);
  assign busy_o = (state_q != TX_IDLE);
  assign done_o = (state_q == TX_STOP) && tick;
  assign txd_o  = txd_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      bit_q   <= '0;
      txd_q   <= 1'b1;
    end else begin
      case (state_q)
        TX_IDLE: if (load_i) begin
          state_q <= TX_START;
          cnt_q   <= '0;
          shift_q <= data_i;
          txd_q   <= 1'b0;
        end
        TX_START: if (tick) begin
          state_q <= TX_DATA;
          cnt_q   <= '0;
          bit_q   <= '0;
          txd_q   <= shift_q[0];
          shift_q <= {1'b0, shift_q[7:1]};
        end else cnt_q <= cnt_q + 16'd1;
        TX_DATA: if (tick) begin
          cnt_q <= '0;
          if (bit_q == 3'd7) begin
            state_q <= TX_STOP;
            txd_q   <= 1'b1;
          end else begin
            bit_q   <= bit_q + 3'd1;
            txd_q   <= shift_q[0];
            shift_q <= {1'b0, shift_q[7:1]};
          end
        end else cnt_q <= cnt_q + 16'd1;
        TX_STOP: if (tick) begin
          state_q <= TX_IDLE;
          cnt_q   <= '0;
        end else cnt_q <= cnt_q + 16'd1;
        default: state_q <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/qbus_dl11.sv
// qbus_dl11 -- DL11 console terminal as a QBUS target (RCSR/RBUF/XCSR/XBUF at BASE).
// Ports: pin_clk, pin_init_n (async low); pin_ad_n inverted AD in; ad_out_n/ad_oe
// read data/vector to external drivers; QBUS strobes pin_sync_n, pin_din_n,
// pin_dout_n, pin_wtbt_n, pin_bs_n, pin_iako_n; pin_rply_n, pin_virq_n out;
// rx_data/rx_stb parallel receive; txd serial transmit.
// Optional: define QBUS_DL11_MAINT_EN for the XCSR MAINT loopback bit.
module qbus_dl11
  import qbus_dl11_pkg::*;
#(
  parameter logic [12:0] BASE     = 13'o17560,
  parameter logic [15:0] RX_VEC   = 16'o000060,
  parameter logic [15:0] TX_VEC   = 16'o000064,
  parameter logic [15:0] BAUD_DIV = 16'd434,
  parameter int          RPLY_DLY = 2
) (
  input  logic        pin_clk,
  input  logic        pin_init_n,
  input  logic [15:0] pin_ad_n,
  output logic [15:0] ad_out_n,
  output logic        ad_oe,
  input  logic        pin_sync_n,
  input  logic        pin_din_n,
  input  logic        pin_dout_n,
  input  logic        pin_wtbt_n,
  input  logic        pin_bs_n,
  input  logic        pin_iako_n,
  output logic        pin_rply_n,
  output logic        pin_virq_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_stb,
  output logic        txd
);

  localparam int S_SYNC = 5, S_DIN = 4, S_DOUT = 3, S_WTBT = 2, S_BS = 1, S_IAKO = 0;

  // Two-flop synchronizers (reset to inactive-high) plus a previous copy of
  // the three edge-detected strobes.
  logic [5:0] meta_q, strb_q;
  logic [2:0] prev_q;
  always_ff @(posedge pin_clk or negedge pin_init_n) begin
    if (!pin_init_n) begin
      meta_q <= '1;
      strb_q <= '1;
      prev_q <= '1;
    end else begin
      meta_q <= {pin_sync_n, pin_din_n, pin_dout_n, pin_wtbt_n, pin_bs_n, pin_iako_n};
      strb_q <= meta_q;
      prev_q <= strb_q[5:3];
    end
  end

  logic sync_fall, sync_rise, din_fall, din_rise, dout_fall, dout_rise;
  assign sync_fall = prev_q[2] & ~strb_q[S_SYNC];
  assign sync_rise = ~prev_q[2] & strb_q[S_SYNC];
  assign din_fall  = prev_q[1] & ~strb_q[S_DIN];
  assign din_rise  = ~prev_q[1] & strb_q[S_DIN];
  assign dout_fall = prev_q[0] & ~strb_q[S_DOUT];
  assign dout_rise = ~prev_q[0] & strb_q[S_DOUT];

  logic unused_hi;
  assign unused_hi = ^pin_ad_n[15:13];

  // Address phase: only the register/byte select survives; the page match
  // is folded into sel_q at latch time.
  logic [2:0] addr_q;
  logic       sel_q;
  always_ff @(posedge pin_clk or negedge pin_init_n) begin
    if (!pin_init_n) begin
      addr_q <= '0;
      sel_q  <= 1'b0;
    end else if (sync_fall) begin
      addr_q <= ~pin_ad_n[2:0];
      sel_q  <= ~strb_q[S_BS] && (~pin_ad_n[12:3] == BASE[12:3]);
    end else if (sync_rise) begin
      sel_q  <= 1'b0;
    end
  end

  // CSR state
  logic       rie_q, xie_q, done_q, ovr_q, rdy_q;
  logic [7:0] rbuf_q;
  logic       rx_req_q, tx_req_q, rx_prev_q, tx_prev_q;
`ifdef QBUS_DL11_MAINT_EN
  logic       maint_q;
  logic [7:0] xbuf_q;
`endif

  logic [7:0]  wdata;
  logic [15:0] rdata, vec;
  logic        din_go, iak_go, dout_go, wr_en, rd_rbuf;
  logic        tx_load, tx_busy, tx_done, tx_txd;
  logic        rx_load, rx_iak, tx_iak, rx_cond, tx_cond;
  logic [7:0]  rx_byte;

  assign wdata   = ~pin_ad_n[7:0];
  assign din_go  = din_fall & ~strb_q[S_SYNC] & sel_q;
  assign iak_go  = din_fall & strb_q[S_SYNC] & ~strb_q[S_IAKO] & (rx_req_q | tx_req_q);
  assign dout_go = dout_fall & ~strb_q[S_SYNC] & sel_q;
  // A byte write to the odd byte touches no writable bit.
  assign wr_en   = dout_go & ~(~strb_q[S_WTBT] & addr_q[0]);
  assign rd_rbuf = din_go & (addr_q[2:1] == RBUF_OFS);
  assign tx_load = wr_en & (addr_q[2:1] == XBUF_OFS) & rdy_q & ~tx_busy;
  assign rx_iak  = iak_go & rx_req_q;
  assign tx_iak  = iak_go & ~rx_req_q;
  assign vec     = rx_req_q ? RX_VEC : TX_VEC;
  assign rx_cond = done_q & rie_q;
  assign tx_cond = rdy_q & xie_q;

`ifdef QBUS_DL11_MAINT_EN
  // Loopback delivers the sent byte as if it had arrived on rx_stb.
  assign rx_load = rx_stb | (tx_done & maint_q);
  assign rx_byte = rx_stb ? rx_data : xbuf_q;
  assign txd     = maint_q ? 1'b1 : tx_txd;
`else
  assign rx_load = rx_stb;
  assign rx_byte = rx_data;
  assign txd     = tx_txd;
`endif

  always_comb begin
    rdata = '0;
    case (addr_q[2:1])
      RCSR_OFS: begin
        rdata[DONE_BIT] = done_q;
        rdata[IE_BIT]   = rie_q;
      end
      RBUF_OFS: begin
        rdata[OVR_HI_BIT] = ovr_q;
        rdata[OVR_LO_BIT] = ovr_q;
        rdata[7:0]        = rbuf_q;
      end
      XCSR_OFS: begin
        rdata[DONE_BIT] = rdy_q;
        rdata[IE_BIT]   = xie_q;
`ifdef QBUS_DL11_MAINT_EN
        rdata[MAINT_BIT] = maint_q;
`endif
      end
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge pin_clk or negedge pin_init_n) begin
    if (!pin_init_n) begin
      rie_q  <= 1'b0;
      xie_q  <= 1'b0;
      done_q <= 1'b0;
      ovr_q  <= 1'b0;
      rdy_q  <= 1'b1;
      rbuf_q <= '0;
`ifdef QBUS_DL11_MAINT_EN
      maint_q <= 1'b0;
      xbuf_q  <= '0;
`endif
    end else begin
      // A byte landing on the same cycle as an RBUF read wins, OVR cleared.
      if (rx_load) begin
        rbuf_q <= rx_byte;
        done_q <= 1'b1;
        ovr_q  <= done_q & ~rd_rbuf;
      end else if (rd_rbuf) begin
        done_q <= 1'b0;
        ovr_q  <= 1'b0;
      end
      if (wr_en && addr_q[2:1] == RCSR_OFS) rie_q <= wdata[IE_BIT];
      if (wr_en && addr_q[2:1] == XCSR_OFS) begin
        xie_q <= wdata[IE_BIT];
`ifdef QBUS_DL11_MAINT_EN
        maint_q <= wdata[MAINT_BIT];
`endif
      end
      if (tx_load) begin
        rdy_q <= 1'b0;
`ifdef QBUS_DL11_MAINT_EN
        xbuf_q <= wdata;
`endif
      end else if (tx_done) begin
        rdy_q <= 1'b1;
      end
    end
  end

  // Interrupt requests fire on the rising edge of each enable&flag condition.
  always_ff @(posedge pin_clk or negedge pin_init_n) begin
    if (!pin_init_n) begin
      rx_prev_q <= 1'b0;
      tx_prev_q <= 1'b0;
      rx_req_q  <= 1'b0;
      tx_req_q  <= 1'b0;
    end else begin
      rx_prev_q <= rx_cond;
      tx_prev_q <= tx_cond;
      if (rx_cond & ~rx_prev_q)   rx_req_q <= 1'b1;
      else if (~rx_cond | rx_iak) rx_req_q <= 1'b0;
      if (tx_cond & ~tx_prev_q)   tx_req_q <= 1'b1;
      else if (~tx_cond | tx_iak) tx_req_q <= 1'b0;
    end
  end
  assign pin_virq_n = ~(rx_req_q | tx_req_q);

  // Bus reply: data drives at once, RPLY follows RPLY_DLY cycles later.
  logic [15:0] ad_out_q;
  logic        oe_q, rply_q;
  logic [2:0]  dly_q;
  always_ff @(posedge pin_clk or negedge pin_init_n) begin
    if (!pin_init_n) begin
      ad_out_q <= '1;
      oe_q     <= 1'b0;
      rply_q   <= 1'b0;
      dly_q    <= '0;
    end else begin
      if (din_go | iak_go) begin
        ad_out_q <= iak_go ? ~vec : ~rdata;
        oe_q     <= 1'b1;
      end
      if (din_go | iak_go | dout_go) begin
        if (RPLY_DLY == 0) rply_q <= 1'b1;
        else               dly_q  <= 3'(RPLY_DLY);
      end else if (dly_q != 3'd0) begin
        dly_q <= dly_q - 3'd1;
        if (dly_q == 3'd1) rply_q <= 1'b1;
      end
      if (din_rise | dout_rise) begin
        ad_out_q <= '1;
        oe_q     <= 1'b0;
        rply_q   <= 1'b0;
        dly_q    <= '0;
      end
    end
  end
  assign ad_out_n   = ad_out_q;
  assign ad_oe      = oe_q;
  assign pin_rply_n = ~rply_q;

  dl11_tx #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .clk_i  (pin_clk),
    .rst_ni (pin_init_n),
    .load_i (tx_load),
    .data_i (wdata),
    .busy_o (tx_busy),
    .done_o (tx_done),
    .txd_o  (tx_txd)
  );

endmodule

// File: tb/tb_qbus_dl11.sv
// tb_qbus_dl11 -- directed QBUS master stimulus; read/IAK data is checked by a
// scoreboard monitor that pops expected words whenever the DUT replies.
module tb_qbus_dl11;

  localparam int RPLY_DLY = 2;
  localparam logic [15:0] A_RCSR = 16'o177560;
  localparam logic [15:0] A_RBUF = 16'o177562;
  localparam logic [15:0] A_XCSR = 16'o177564;
  localparam logic [15:0] A_XBUF = 16'o177566;

  logic        pin_clk = 1'b0;
  logic        pin_init_n = 1'b0;
  logic [15:0] pin_ad_n = '1;
  logic        pin_sync_n = 1'b1, pin_din_n = 1'b1, pin_dout_n = 1'b1;
  logic        pin_wtbt_n = 1'b1, pin_bs_n = 1'b1, pin_iako_n = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_stb = 1'b0;
  logic [15:0] ad_out_n;
  logic        ad_oe, pin_rply_n, pin_virq_n, txd;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_v[$];
  string       exp_n[$];

  always #5 pin_clk = ~pin_clk;

  qbus_dl11 #(.BAUD_DIV(16'd4), .RPLY_DLY(RPLY_DLY)) dut (
    .pin_clk(pin_clk), .pin_init_n(pin_init_n), .pin_ad_n(pin_ad_n),
    .ad_out_n(ad_out_n), .ad_oe(ad_oe),
    .pin_sync_n(pin_sync_n), .pin_din_n(pin_din_n), .pin_dout_n(pin_dout_n),
    .pin_wtbt_n(pin_wtbt_n), .pin_bs_n(pin_bs_n), .pin_iako_n(pin_iako_n),
    .pin_rply_n(pin_rply_n), .pin_virq_n(pin_virq_n),
    .rx_data(rx_data), .rx_stb(rx_stb), .txd(txd)
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %06o want %06o", nm, act, exp);
    end
  endtask

  // Monitor: on each new reply with drivers enabled, pop and compare; also
  // check the data-to-RPLY spacing.
  initial begin
    logic rply_prev;
    int   oe_cnt;
    string nm;
    rply_prev = 1'b1;
    oe_cnt = 0;
    forever begin
      @(negedge pin_clk);
      if (ad_oe && pin_rply_n) oe_cnt++;
      else if (ad_oe && !pin_rply_n && rply_prev) begin
        if (exp_v.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_reply: got %06o want none", ~ad_out_n);
        end else begin
          nm = exp_n.pop_front();
          chk(nm, ~ad_out_n, exp_v.pop_front());
          chk({nm, "_dly"}, 16'(oe_cnt), 16'(RPLY_DLY));
        end
      end
      if (!ad_oe) oe_cnt = 0;
      rply_prev = pin_rply_n;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge pin_clk); #1; end
  endtask

  task automatic wait_rply(input logic lvl, input string nm);
    int i;
    i = 0;
    while (pin_rply_n !== lvl && i < 40) begin tick(1); i++; end
    chk(nm, {15'b0, pin_rply_n}, {15'b0, lvl});
  endtask

  task automatic addr_phase(input logic [15:0] a, input logic wr);
    pin_ad_n   = ~a;
    pin_bs_n   = ~(a[15:13] == 3'b111);
    pin_wtbt_n = ~wr;
    tick(1);
    pin_sync_n = 1'b0;
    tick(4);
    pin_ad_n = '1;
    pin_bs_n = 1'b1;
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] e, input string nm);
    addr_phase(a, 1'b0);
    exp_v.push_back(e); exp_n.push_back(nm);
    pin_din_n = 1'b0;
    wait_rply(1'b0, {nm, "_rply"});
    pin_din_n = 1'b1;
    wait_rply(1'b1, {nm, "_rel"});
    pin_sync_n = 1'b1;
    tick(2);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic bytew);
    addr_phase(a, 1'b1);
    pin_ad_n = ~d; pin_wtbt_n = ~bytew; pin_dout_n = 1'b0;
    wait_rply(1'b0, "wr_rply");
    pin_dout_n = 1'b1; pin_ad_n = '1; pin_wtbt_n = 1'b1;
    wait_rply(1'b1, "wr_rel");
    pin_sync_n = 1'b1;
    tick(2);
  endtask

  task automatic iak(input logic [15:0] e, input string nm);
    exp_v.push_back(e); exp_n.push_back(nm);
    pin_iako_n = 1'b0; pin_din_n = 1'b0;
    wait_rply(1'b0, {nm, "_rply"});
    pin_din_n = 1'b1; pin_iako_n = 1'b1;
    wait_rply(1'b1, {nm, "_rel"});
    tick(2);
  endtask

  task automatic rxb(input logic [7:0] d);
    rx_data = d; rx_stb = 1'b1; tick(1);
    rx_stb = 1'b0; tick(1);
  endtask

  initial begin
    logic [9:0] txexp;
    int t;
    txexp = 10'b1010000010;   // start, 0x41 LSB first, stop
    tick(3);
    chk("rst_rply_n", {15'b0, pin_rply_n}, 16'd1);
    chk("rst_ad_oe", {15'b0, ad_oe}, 16'd0);
    chk("rst_ad_out_n", ad_out_n, 16'hFFFF);
    chk("rst_virq_n", {15'b0, pin_virq_n}, 16'd1);
    chk("rst_txd", {15'b0, txd}, 16'd1);
    pin_init_n = 1'b1;
    tick(3);

    rd(A_XCSR, 16'o000200, "xcsr_reset");
    rd(A_RCSR, 16'o000000, "rcsr_reset");

    // Transmit 0101 and watch the line at mid-bit
    fork
      begin : tx_mon
        int tt;
        tt = 0;
        while (txd !== 1'b0 && tt < 200) begin @(negedge pin_clk); tt++; end
        chk("tx_start_seen", {15'b0, txd}, 16'd0);
        repeat (2) @(negedge pin_clk);
        for (int k = 0; k < 10; k++) begin
          if (k != 0) repeat (4) @(negedge pin_clk);
          chk($sformatf("txd_bit%0d", k), {15'b0, txd}, {15'b0, txexp[k]});
        end
      end
      begin
        wr(A_XBUF, 16'o000101, 1'b0);
        rd(A_XCSR, 16'o000000, "xcsr_busy");
      end
    join
    tick(5);
    rd(A_XCSR, 16'o000200, "xcsr_after_tx");

    // Transmitter interrupt
    wr(A_XCSR, 16'o000100, 1'b0);
    chk("virq_tx", {15'b0, pin_virq_n}, 16'd0);
    iak(16'o000064, "iak_tx");
    chk("virq_cleared", {15'b0, pin_virq_n}, 16'd1);
    tick(10);
    chk("virq_no_rereq", {15'b0, pin_virq_n}, 16'd1);

    // Overrun
    rxb(8'h41);
    rxb(8'h42);
    rd(A_RBUF, 16'o140102, "rbuf_ovr");
    rd(A_RBUF, 16'o000102, "rbuf_again");
    rd(A_RCSR, 16'o000000, "rcsr_done_clr");

    // Both requests pending: receiver first
    wr(A_RCSR, 16'o000100, 1'b0);
    rxb(8'h33);
    wr(A_XCSR, 16'o000000, 1'b0);
    wr(A_XCSR, 16'o000100, 1'b0);
    chk("virq_both", {15'b0, pin_virq_n}, 16'd0);
    iak(16'o000060, "iak_rx_first");
    iak(16'o000064, "iak_tx_second");
    chk("virq_both_clr", {15'b0, pin_virq_n}, 16'd1);
    rd(A_RBUF, 16'o000063, "rbuf_33");
    rd(A_RCSR, 16'o000100, "rcsr_rie");

    // Byte writes: odd byte ignored, even byte applies
    wr(A_XCSR + 16'd1, 16'o000000, 1'b1);
    rd(A_XCSR, 16'o000300, "xcsr_odd_byte");
    wr(A_RCSR, 16'o000000, 1'b1);
    rd(A_RCSR, 16'o000000, "rcsr_even_byte");

    // Busy XBUF write is dropped; RDY return re-raises the tx request
    wr(A_XBUF, 16'o000000, 1'b0);
    wr(A_XBUF, 16'o000377, 1'b0);
    tick(45);
    chk("virq_rdy_toggle", {15'b0, pin_virq_n}, 16'd0);
    iak(16'o000064, "iak_tx_again");
    rd(A_XCSR, 16'o000300, "xcsr_idle");

    // Reset in the middle of a frame
    wr(A_XBUF, 16'o000000, 1'b0);
    t = 0;
    while (txd !== 1'b0 && t < 100) begin tick(1); t++; end
    chk("tx2_start_seen", {15'b0, txd}, 16'd0);
    tick(3);
    pin_init_n = 1'b0;
    #1;
    chk("midrst_txd", {15'b0, txd}, 16'd1);
    chk("midrst_virq", {15'b0, pin_virq_n}, 16'd1);
    tick(2);
    pin_init_n = 1'b1;
    tick(3);
    rd(A_XCSR, 16'o000200, "xcsr_post_rst");

`ifdef QBUS_DL11_MAINT_EN
    begin
      logic seen0;
      seen0 = 1'b0;
      wr(A_XCSR, 16'o000004, 1'b0);
      wr(A_XBUF, 16'o000125, 1'b0);
      for (int j = 0; j < 50; j++) begin
        if (txd !== 1'b1) seen0 = 1'b1;
        tick(1);
      end
      chk("maint_txd_high", {15'b0, seen0}, 16'd0);
      rd(A_RCSR, 16'o000200, "maint_done");
      rd(A_RBUF, 16'o000125, "maint_rbuf");
      rd(A_XCSR, 16'o000204, "maint_xcsr");
    end
`endif

    tick(4);
    chk("scoreboard_drain", 16'(exp_v.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
